// File: rtl/sal_ddr2_pkg.sv
// -----------------------------------------------------------------------------
// sal_ddr2_pkg
// Shared definitions for the DDR2 command path:
//   - cmd_type_t : DFI command encoding (NOP, ACT, RD, WR, PRE, REF)
//   - cas_dir_t  : direction of the most recent CAS command
//   - default bank count, bank-index width and inter-bank timing values
// -----------------------------------------------------------------------------
package sal_ddr2_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_type_t;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } cas_dir_t;

    localparam int DEF_BK_CNT   = 8;
    localparam int DEF_BK_IDX_W = $clog2(DEF_BK_CNT);

    // Inter-bank timing defaults, in controller clock cycles.
    localparam int DEF_T_RRD = 2;
    localparam int DEF_T_CCD = 2;
    localparam int DEF_T_WTR = 3;
    localparam int DEF_T_RTW = 4;

endpackage

// File: rtl/sal_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sal_rr_arbiter
// Purely combinational round-robin picker. The winner is the first set bit of
// req at or after ptr, wrapping modulo N (N must be a power of two so the
// index arithmetic wraps naturally in PW bits).
// Ports:
//   req     in  N   request vector
//   ptr     in  PW  current round-robin pointer
//   gnt     out N   one-hot grant (zero when req is zero)
//   gnt_idx out PW  index of the winning bit (0 when req is zero)
//   nxt_ptr out PW  winner+1 (equals ptr when req is zero)
// -----------------------------------------------------------------------------
module sal_rr_arbiter #(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic [PW-1:0] nxt_ptr
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        nxt_ptr = ptr;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + PW'(i);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
                nxt_ptr    = idx + PW'(1);
            end
        end
    end

endmodule

// File: rtl/sal_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// sal_cmd_arbiter
// Multi-bank command arbiter between the per-bank FSMs and the DFI command
// bus. Each cycle at most one request is granted, chosen by class priority
// (REF > PRE > CAS > ACT) and per-class round-robin, while the inter-bank
// timing constraints tRRD, tCCD, tWTR and tRTW are enforced. The grant is
// combinational; the resulting DFI command is registered one cycle later.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   act/rd/wr/pre_req     per-bank requests (BK_CNT bits each)
//   ref_req               per-bank refresh-ready; REF only when all set
//   act/rd/wr/pre_gnt     one-hot combinational grants
//   ref_gnt               all-ones when refresh is granted
//   cmd_valid             registered DFI command valid
//   cmd_type              registered DFI command (cmd_type_t encoding)
//   cmd_bank              registered target bank (0 for REF)
// -----------------------------------------------------------------------------
module sal_cmd_arbiter
    import sal_ddr2_pkg::*;
#(
    parameter int BK_CNT = DEF_BK_CNT,
    parameter int T_RRD  = DEF_T_RRD,
    parameter int T_CCD  = DEF_T_CCD,
    parameter int T_WTR  = DEF_T_WTR,
    parameter int T_RTW  = DEF_T_RTW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BK_CNT-1:0]         act_req,
    input  logic [BK_CNT-1:0]         rd_req,
    input  logic [BK_CNT-1:0]         wr_req,
    input  logic [BK_CNT-1:0]         pre_req,
    input  logic [BK_CNT-1:0]         ref_req,
    output logic [BK_CNT-1:0]         act_gnt,
    output logic [BK_CNT-1:0]         rd_gnt,
    output logic [BK_CNT-1:0]         wr_gnt,
    output logic [BK_CNT-1:0]         pre_gnt,
    output logic [BK_CNT-1:0]         ref_gnt,
    output logic                      cmd_valid,
    output logic [2:0]                cmd_type,
    output logic [$clog2(BK_CNT)-1:0] cmd_bank
);

    localparam int BW = $clog2(BK_CNT);

    // A constraint of T cycles is held off by loading T-1; T<=1 loads 0 so
    // back-to-back issue is allowed. Values beyond the counter range clamp.
    function automatic logic [3:0] timing_load(input int t);
        if (t <= 1) begin
            return 4'd0;
        end else if (t > 16) begin
            return 4'hF;
        end else begin
            return 4'(t - 1);
        end
    endfunction

    // Down-counter step that sticks at zero.
    function automatic logic [3:0] dec_sat(input logic [3:0] c);
        return (c == 4'd0) ? 4'd0 : c - 4'd1;
    endfunction

    logic [3:0]        rrd_cnt;
    logic [3:0]        ccd_cnt;
    logic [3:0]        wtr_cnt;
    logic [3:0]        rtw_cnt;
    logic [BW-1:0]     pre_ptr;
    logic [BW-1:0]     cas_ptr;
    logic [BW-1:0]     act_ptr;
    cas_dir_t          last_dir;

    logic              ref_all;
    logic              pre_any;
    logic              rd_elig;
    logic              wr_elig;
    logic              act_elig;
    logic              sel_wr;
    logic [BK_CNT-1:0] cas_req;

    logic [BK_CNT-1:0] pre_arb_gnt;
    logic [BK_CNT-1:0] cas_arb_gnt;
    logic [BK_CNT-1:0] act_arb_gnt;
    logic [BW-1:0]     pre_idx;
    logic [BW-1:0]     cas_idx;
    logic [BW-1:0]     act_idx;
    logic [BW-1:0]     pre_nxt;
    logic [BW-1:0]     cas_nxt;
    logic [BW-1:0]     act_nxt;

    cmd_type_t         grant_cls;
    logic [BW-1:0]     grant_bank;

    logic              cmd_vld_p1;
    cmd_type_t         cmd_type_p1;
    logic [BW-1:0]     cmd_bank_p1;

    // ---- stage p0: eligibility, arbitration and combinational grant ----
    assign ref_all  = &ref_req;
    assign pre_any  = |pre_req;
    assign rd_elig  = (|rd_req) && (ccd_cnt == 4'd0) && (wtr_cnt == 4'd0);
    assign wr_elig  = (|wr_req) && (ccd_cnt == 4'd0) && (rtw_cnt == 4'd0);
    assign act_elig = (|act_req) && (rrd_cnt == 4'd0);

    // When both directions are legal, keep the bus turned the way it already
    // faces to avoid paying a turnaround.
    assign sel_wr  = wr_elig && (!rd_elig || (last_dir == DIR_WRITE));
    // RD and WR share one pointer, so a single arbiter serves the selected one.
    assign cas_req = sel_wr ? wr_req : rd_req;

    sal_rr_arbiter #(.N(BK_CNT), .PW(BW)) u_pre_arb (
        .req     (pre_req),
        .ptr     (pre_ptr),
        .gnt     (pre_arb_gnt),
        .gnt_idx (pre_idx),
        .nxt_ptr (pre_nxt)
    );

    sal_rr_arbiter #(.N(BK_CNT), .PW(BW)) u_cas_arb (
        .req     (cas_req),
        .ptr     (cas_ptr),
        .gnt     (cas_arb_gnt),
        .gnt_idx (cas_idx),
        .nxt_ptr (cas_nxt)
    );

    sal_rr_arbiter #(.N(BK_CNT), .PW(BW)) u_act_arb (
        .req     (act_req),
        .ptr     (act_ptr),
        .gnt     (act_arb_gnt),
        .gnt_idx (act_idx),
        .nxt_ptr (act_nxt)
    );

    // Ineligible classes fall through to the next one rather than stalling.
    always_comb begin
        grant_cls  = CMD_NOP;
        grant_bank = '0;
        if (!rst_n) begin
            grant_cls  = CMD_NOP;
        end else if (ref_all) begin
            grant_cls  = CMD_REF;
        end else if (pre_any) begin
            grant_cls  = CMD_PRE;
            grant_bank = pre_idx;
        end else if (rd_elig || wr_elig) begin
            grant_cls  = sel_wr ? CMD_WR : CMD_RD;
            grant_bank = cas_idx;
        end else if (act_elig) begin
            grant_cls  = CMD_ACT;
            grant_bank = act_idx;
        end
    end

    assign pre_gnt = (grant_cls == CMD_PRE) ? pre_arb_gnt : '0;
    assign rd_gnt  = (grant_cls == CMD_RD)  ? cas_arb_gnt : '0;
    assign wr_gnt  = (grant_cls == CMD_WR)  ? cas_arb_gnt : '0;
    assign act_gnt = (grant_cls == CMD_ACT) ? act_arb_gnt : '0;
    assign ref_gnt = {BK_CNT{grant_cls == CMD_REF}};

    // ---- stage p1: timing/pointer state update and registered DFI command ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_cnt     <= 4'd0;
            ccd_cnt     <= 4'd0;
            wtr_cnt     <= 4'd0;
            rtw_cnt     <= 4'd0;
            pre_ptr     <= '0;
            cas_ptr     <= '0;
            act_ptr     <= '0;
            last_dir    <= DIR_READ;
            cmd_vld_p1  <= 1'b0;
            cmd_type_p1 <= CMD_NOP;
            cmd_bank_p1 <= '0;
        end else begin
            // A load in the grant cycle overrides that cycle's decrement.
            rrd_cnt <= (grant_cls == CMD_ACT) ? timing_load(T_RRD) : dec_sat(rrd_cnt);
            ccd_cnt <= (grant_cls == CMD_RD || grant_cls == CMD_WR) ?
                       timing_load(T_CCD) : dec_sat(ccd_cnt);
            wtr_cnt <= (grant_cls == CMD_WR) ? timing_load(T_WTR) : dec_sat(wtr_cnt);
            rtw_cnt <= (grant_cls == CMD_RD) ? timing_load(T_RTW) : dec_sat(rtw_cnt);

            if (grant_cls == CMD_PRE) begin
                pre_ptr <= pre_nxt;
            end
            if (grant_cls == CMD_RD || grant_cls == CMD_WR) begin
                cas_ptr  <= cas_nxt;
                last_dir <= (grant_cls == CMD_WR) ? DIR_WRITE : DIR_READ;
            end
            if (grant_cls == CMD_ACT) begin
                act_ptr <= act_nxt;
            end

            cmd_vld_p1  <= (grant_cls != CMD_NOP);
            cmd_type_p1 <= grant_cls;
            cmd_bank_p1 <= grant_bank;
        end
    end

    assign cmd_valid = cmd_vld_p1;
    assign cmd_type  = cmd_type_p1;
    assign cmd_bank  = cmd_bank_p1;

endmodule
